ema_inverse: RTL and testbench

- Inverse of the EMA smoothing filter.
- Takes the smoothed stream y[n] and the same alpha the forward filter used, and reconstructs the raw sample x[n] = (y[n] − (1−α)·y[n−1]) / α.
- Sits after the forward filter for loopback verification and for de-smoothing logged sensor data.
- Uses the same handshake as the forward filter (valid_i / busy_o / valid_o) and the same Q0.(Win−1) alpha format, with (1−α) taken as ~alpha.

---
 rtl/ema_pkg.sv | 33 +++
 rtl/seq_divider.sv | 69 ++++++
 rtl/ema_inverse.sv | 130 +++++++++++++
 tb/tb_ema_inverse.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ema_pkg.sv
// ============================================================================
// Module      : ema_pkg
// Description : Shared definitions for the EMA inverse filter: FSM state
//               encoding and saturation bounds.
//               Q-format note: alpha is unsigned Q0.(Win-1), and (1 - alpha)
//               is represented as ~alpha in the same format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ema_pkg;

  // Sequencer states: accept -> multiply -> iterative divide -> publish
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } ema_state_t;

  // Largest value representable in a w-bit two's complement word
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit two's complement word
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per cycle,
//               MSB first. A start pulse loads the operands; DW further
//               cycles produce the quotient. 'done' is high during the cycle
//               in which the last iteration is being performed, and
//               'quotient' presents the post-iteration value so the parent
//               can register the final result on that same edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int DW = 32,
  parameter int VW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int c_cw = $clog2(DW + 1);

  logic [DW-1:0]   r_dq;
  logic [VW-1:0]   r_rem;
  logic [VW-1:0]   r_dvs;
  logic [c_cw-1:0] r_cnt;

  logic [VW:0]     w_shift;
  logic            w_ge;
  logic [VW-1:0]   w_rem_next;
  logic [VW:0]     w_diff;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    w_shift    = {r_rem, r_dq[DW-1]};
    w_diff     = w_shift - {1'b0, r_dvs};
    w_ge       = (w_shift >= {1'b0, r_dvs});
    w_rem_next = w_ge ? w_diff[VW-1:0] : w_shift[VW-1:0];
    quotient   = {r_dq[DW-2:0], w_ge};
    done       = (r_cnt == c_cw'(1));
  end

  // Operand load on start, then one iteration per cycle until the count expires
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dq  <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_dq  <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
      r_cnt <= c_cw'(DW);
    end else if (r_cnt != '0) begin
      r_dq  <= quotient;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt - c_cw'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ema_inverse.sv
// ============================================================================
// Module      : ema_inverse
// Description : Inverse EMA filter. Reconstructs the raw sample
//               x[n] = (y[n] - (1-a)*y[n-1]) / a from the smoothed stream,
//               using a one-cycle multiply and a sequential divider.
//               Result truncates toward zero and saturates to Wout bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ema_inverse
  import ema_pkg::*;
#(
  parameter int Win  = 16,
  parameter int Wout = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [Win-1:0]  y_i,
  input  logic [Win-2:0]         alpha_i,
  input  logic                   valid_i,
  output logic signed [Wout-1:0] x_o,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic                   div0_o
);

  localparam int c_dw = 2 * Win;

  ema_state_t             r_state;
  logic signed [Win-1:0]  r_y;
  logic signed [Win-1:0]  r_y_last;
  logic [Win-2:0]         r_a;
  logic                   r_sign;

  logic signed [c_dw-1:0] w_d;
  logic [c_dw-1:0]        w_mag;
  logic                   w_start;
  logic                   w_div_done;
  logic [c_dw-1:0]        w_quot;
  logic signed [c_dw-1:0] w_q;
  logic signed [Wout-1:0] w_x_sat;

  // Numerator y*2^(Win-1) - y_last*(1-a); its magnitude feeds the divider
  always_comb begin
    w_d = (c_dw'(r_y) <<< (Win - 1))
        - ($signed(c_dw'(r_y_last)) * $signed(c_dw'({1'b0, ~r_a})));
    w_mag   = w_d[c_dw-1] ? c_dw'(-w_d) : c_dw'(w_d);
    w_start = (r_state == ST_MULT) && (r_a != '0);
  end

  // Restore sign (truncation toward zero) and clamp to the output range
  always_comb begin
    w_q     = r_sign ? -$signed(w_quot) : $signed(w_quot);
    w_x_sat = Wout'(w_q);
    if (longint'(w_q) > sat_max(Wout)) begin
      w_x_sat = {1'b0, {(Wout-1){1'b1}}};
    end else if (longint'(w_q) < sat_min(Wout)) begin
      w_x_sat = {1'b1, {(Wout-1){1'b0}}};
    end
  end

  seq_divider #(
    .DW (c_dw),
    .VW (Win - 1)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .dividend (w_mag),
    .divisor  (r_a),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  // Sequencer with registered outputs; reset discards any division in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_y      <= '0;
      r_y_last <= '0;
      r_a      <= '0;
      r_sign   <= 1'b0;
      x_o      <= '0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      div0_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            r_y     <= y_i;
            r_a     <= alpha_i;
            busy_o  <= 1'b1;
            r_state <= ST_MULT;
          end
        end
        ST_MULT: begin
          r_sign <= w_d[c_dw-1];
          if (r_a == '0) begin
            x_o     <= '0;
            div0_o  <= 1'b1;
            valid_o <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            x_o     <= w_x_sat;
            valid_o <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_y_last <= r_y;
          busy_o   <= 1'b0;
          div0_o   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ema_inverse.sv
// ============================================================================
// Module      : tb_ema_inverse
// Description : Directed self-checking bench for ema_inverse: reset, basic
//               reconstruction, divide-by-zero, saturation, handshake timing,
//               mid-division reset and loopback against a forward EMA model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ema_inverse;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic signed [15:0]  y_i = '0;
  logic [14:0]         alpha_i = '0;
  logic                valid_i = 1'b0;
  logic signed [15:0]  x_o;
  logic                busy_o;
  logic                valid_o;
  logic                div0_o;

  int errors = 0;
  int checks = 0;

  int                 lat;
  logic signed [15:0] got_x;
  logic               got_d0;

  always #5 clk = ~clk;

  ema_inverse #(
    .Win  (16),
    .Wout (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .y_i     (y_i),
    .alpha_i (alpha_i),
    .valid_i (valid_i),
    .x_o     (x_o),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .div0_o  (div0_o)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Present one sample, then wait (bounded) for the result pulse
  task automatic run_sample(input logic signed [15:0] y, input logic [14:0] a);
    @(negedge clk);
    y_i     = y;
    alpha_i = a;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!valid_o) chk("result_timeout", 0, 1);
    got_x  = x_o;
    got_d0 = div0_o;
  endtask

  function automatic logic signed [15:0] fwd(input logic signed [15:0] x,
                                              input logic signed [15:0] yl,
                                              input logic [14:0] a);
    logic [14:0] na;
    longint acc;
    na  = ~a;
    acc = longint'(a) * longint'(x) + longint'(na) * longint'(yl);
    return 16'(acc >>> 15);
  endfunction

  initial begin
    int nvalid, nbusy, npos;
    int pos[8];
    logic signed [15:0] lx, ly, lyl;
    longint err;
    logic [14:0] la;

    // Reset held with valid_i asserted: nothing may be accepted
    y_i = 16'sd100; alpha_i = 15'h4000; valid_i = 1'b1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", longint'({x_o, valid_o, busy_o, div0_o}), 0);
    end
    valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_no_accept", busy_o, 0);

    // Basic reconstruction with alpha = 0.5
    run_sample(16'sd100, 15'h4000);
    chk("basic1_latency", lat, 34);
    chk("basic1_x", got_x, 200);
    chk("basic1_div0", got_d0, 0);
    run_sample(16'sd100, 15'h4000);
    chk("basic2_x", got_x, 100);

    // Divide by zero, then the following sample still sees y_last=500
    run_sample(16'sd500, 15'h0000);
    chk("div0_latency", lat, 2);
    chk("div0_flag", got_d0, 1);
    chk("div0_x", got_x, 0);
    run_sample(16'sd500, 15'h4000);
    chk("after_div0_x", got_x, 500);
    chk("after_div0_flag", got_d0, 0);

    do_reset();
    run_sample(-16'sd100, 15'h4000);
    chk("neg_x", got_x, -200);

    // Saturation with the smallest non-zero alpha
    do_reset();
    run_sample(16'sd32767, 15'h0001);
    chk("sat_pos", got_x, 32767);
    do_reset();
    run_sample(-16'sd32768, 15'h0001);
    chk("sat_neg", got_x, -32768);

    // Handshake: valid_i held high, one result every 35 cycles
    @(negedge clk);
    y_i = 16'sd100; alpha_i = 15'h4000; valid_i = 1'b1;
    nvalid = 0; nbusy = 0; npos = 0;
    for (int n = 1; n <= 140; n++) begin
      @(negedge clk);
      if (valid_o) begin
        nvalid++;
        if (npos < 8) begin
          pos[npos] = n;
          npos++;
        end
      end
      if (busy_o) nbusy++;
    end
    valid_i = 1'b0;
    chk("hs_valid_count", nvalid, 4);
    chk("hs_busy_cycles", nbusy, 136);
    if (npos > 0) chk("hs_first_pos", pos[0], 34);
    for (int i = 1; i < npos; i++) chk("hs_spacing", pos[i] - pos[i-1], 35);

    // Reset during the division: result discarded, y_last cleared
    @(negedge clk);
    y_i = 16'sd100; alpha_i = 15'h4000; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nvalid = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valid_o) nvalid++;
    end
    chk("middiv_no_valid", nvalid, 0);
    chk("middiv_idle", busy_o, 0);
    run_sample(16'sd100, 15'h4000);
    chk("middiv_ylast_zero", got_x, 200);

    // Loopback against a forward EMA model, error bounded by 2^16/alpha
    for (int g = 0; g < 3; g++) begin
      la = (g == 0) ? 15'h0400 : (g == 1) ? 15'h4000 : 15'h7FFF;
      do_reset();
      lyl = '0;
      for (int i = 0; i < ((g == 0) ? 334 : 333); i++) begin
        lx = $signed(16'($urandom));
        ly = fwd(lx, lyl, la);
        run_sample(ly, la);
        err = longint'(got_x) - longint'(lx);
        if (err < 0) err = -err;
        chk("loopback_err_bound", longint'(err * longint'(la) < 65536), 1);
        lyl = ly;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
